// File: rtl/uart_arith_host.sv
// uart_arith_host: UART command front-end that drives an external adder/subtractor
// Optional: define UART_ARITH_TIMEOUT_EN to enable the inter-byte receive timeout (response 0xEF)
// Ports: iClk/iRst clock and synchronous active-high reset; iRx/oTx serial in/out;
//   oStart/oOpA/oOpB/oSub out and iRes/iDone in form the adder handshake;
//   oBusy is high whenever not idle; oErr pulses when an error status is queued
module uart_rx #(
  parameter int CLKS = 1085
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iRx,
  output logic       oDone,
  output logic [7:0] oData
);
  localparam int TW = $clog2(CLKS + 1);
  logic [1:0] sync;
  logic busy;
  logic [TW-1:0] tick;
  logic [3:0] n;
  always_ff @(posedge iClk) begin
    if (iRst) begin
      sync <= 2'b11;
      busy <= 1'b0;
      tick <= '0;
      n <= '0;
      oDone <= 1'b0;
      oData <= '0;
    end else begin
      sync <= {sync[0], iRx};
      oDone <= 1'b0;
      if (!busy) begin
        busy <= !sync[1];
        tick <= TW'(CLKS / 2);
        n <= '0;
      end else if (tick != '0) tick <= tick - 1'b1;
      else begin
        tick <= TW'(CLKS - 1);
        n <= n + 1'b1;
        if (n == 4'd0) busy <= !sync[1];
        else if (n == 4'd9) begin
          busy <= 1'b0;
          oDone <= sync[1];
        end else oData <= {sync[1], oData[7:1]};
      end
    end
  end
endmodule

module uart_tx #(
  parameter int CLKS = 1085
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
  input  logic [7:0] iData,
  output logic       oTx,
  output logic       oBusy,
  output logic       oDone
);
  localparam int TW = $clog2(CLKS + 1);
  logic [9:0] sh;
  logic [TW-1:0] tick;
  logic [3:0] n;
  assign oTx = sh[0];
  always_ff @(posedge iClk) begin
    if (iRst) begin
      sh <= '1;
      oBusy <= 1'b0;
      tick <= '0;
      n <= '0;
      oDone <= 1'b0;
    end else begin
      oDone <= 1'b0;
      if (!oBusy) begin
        if (iStart) begin
          sh <= {1'b1, iData, 1'b0};
          oBusy <= 1'b1;
          tick <= TW'(CLKS - 1);
          n <= '0;
        end
      end else if (tick != '0) tick <= tick - 1'b1;
      else if (n == 4'd9) begin
        oBusy <= 1'b0;
        oDone <= 1'b1;
      end else begin
        sh <= {1'b1, sh[9:1]};
        n <= n + 1'b1;
        tick <= TW'(CLKS - 1);
      end
    end
  end
endmodule

module uart_arith_host #(
  parameter int CLK_FREQ          = 125_000_000,
  parameter int BAUD_RATE         = 115_200,
  parameter int OPERAND_WIDTH     = 1024,
  parameter int RX_TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iRx,
  output logic                     oTx,
  output logic                     oStart,
  output logic [OPERAND_WIDTH-1:0] oOpA,
  output logic [OPERAND_WIDTH-1:0] oOpB,
  output logic                     oSub,
  input  logic [OPERAND_WIDTH:0]   iRes,
  input  logic                     iDone,
  output logic                     oBusy,
  output logic                     oErr
);
  localparam int CLKS = CLK_FREQ / BAUD_RATE;
  localparam int NBYTES = OPERAND_WIDTH / 8;
  localparam int CW = $clog2(NBYTES + 2) + 1;
  localparam int SW = OPERAND_WIDTH + 16;
  typedef enum logic [2:0] {S_IDLE, S_RX_A, S_RX_B, S_START, S_WAIT, S_TX, S_TXW, S_ERR} state_t;
  state_t state, stateNxt;
  logic rxDone, txStart, txBusy, txDone, tmoHit, opOk, lastByte, rxSt;
  logic [7:0] rxData, errCode;
  logic [CW-1:0] rxCnt, txCnt;
  logic [SW-1:0] txSh;
  uart_rx #(.CLKS(CLKS)) uRx (.iClk(iClk), .iRst(iRst), .iRx(iRx), .oDone(rxDone), .oData(rxData));
  uart_tx #(.CLKS(CLKS)) uTx (.iClk(iClk), .iRst(iRst), .iStart(txStart), .iData(txSh[SW-1 -: 8]),
                              .oTx(oTx), .oBusy(txBusy), .oDone(txDone));
  assign rxSt = state == S_RX_A || state == S_RX_B;
  assign lastByte = rxDone && rxCnt == CW'(NBYTES - 1);
  assign opOk = rxData[7:1] == 7'd0;
  assign oBusy = state != S_IDLE;
`ifdef UART_ARITH_TIMEOUT_EN
  localparam int TW = $clog2(RX_TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo;
  always_ff @(posedge iClk) tmo <= (iRst || rxDone || !rxSt) ? '0 : tmo + 1'b1;
  assign tmoHit = tmo == TW'(RX_TIMEOUT_CYCLES);
`else
  // Timeout disabled: the receive states wait indefinitely for the next byte.
  assign tmoHit = RX_TIMEOUT_CYCLES < 0;
`endif
  always_comb begin
    stateNxt = state;
    txStart = 1'b0;
    case (state)
      S_IDLE:  if (rxDone) stateNxt = opOk ? S_RX_A : S_ERR;
      S_RX_A:  stateNxt = lastByte ? S_RX_B : (tmoHit && !rxDone) ? S_ERR : state;
      S_RX_B:  stateNxt = lastByte ? S_START : (tmoHit && !rxDone) ? S_ERR : state;
      S_START: stateNxt = S_WAIT;
      // oStart is registered, so it is still high in the first S_WAIT cycle; a done there is ignored.
      S_WAIT:  if (iDone && !oStart) stateNxt = S_TX;
      S_TX:    if (txCnt == '0) stateNxt = S_IDLE;
               else if (!txBusy) begin
                 txStart = 1'b1;
                 stateNxt = S_TXW;
               end
      S_TXW:   if (txDone) stateNxt = S_TX;
      S_ERR:   stateNxt = S_TX;
      default: stateNxt = S_IDLE;
    endcase
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= S_IDLE;
      rxCnt <= '0;
      txCnt <= '0;
      txSh <= '0;
      errCode <= '0;
      oStart <= 1'b0;
      oOpA <= '0;
      oOpB <= '0;
      oSub <= 1'b0;
      oErr <= 1'b0;
    end else begin
      state <= stateNxt;
      oStart <= state == S_START;
      oErr <= stateNxt == S_ERR;
      rxCnt <= (stateNxt != state || !rxSt) ? '0 : rxCnt + CW'(rxDone);
      if (state == S_IDLE && rxDone && opOk) oSub <= rxData[0];
      if (state == S_RX_A && rxDone) oOpA <= {oOpA[OPERAND_WIDTH-9:0], rxData};
      if (state == S_RX_B && rxDone) oOpB <= {oOpB[OPERAND_WIDTH-9:0], rxData};
      if (stateNxt == S_ERR) begin
        errCode <= state == S_IDLE ? 8'hEE : 8'hEF;
        oOpA <= '0;
        oOpB <= '0;
      end
      if (state == S_WAIT && stateNxt == S_TX) begin
        txSh <= {8'h00, 7'd0, iRes};
        txCnt <= CW'(NBYTES + 2);
      end
      if (state == S_ERR) begin
        txSh <= {errCode, {(SW - 8){1'b0}}};
        txCnt <= CW'(1);
      end
      if (txStart) begin
        txSh <= txSh << 8;
        txCnt <= txCnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_arith_host.sv
// tb_uart_arith_host: randomized self-checking bench for uart_arith_host with a behavioural adder
module tb_uart_arith_host;
  localparam int CLKS = 10;
  localparam int W = 16;
  logic iClk = 1'b0, iRst = 1'b1, iRx = 1'b1, iDone = 1'b0;
  logic oTx, oStart, oSub, oBusy, oErr;
  logic [W-1:0] oOpA, oOpB, seenA, seenB;
  logic [W:0] iRes, addRes;
  logic seenSub;
  int addCnt = 0, startCnt = 0, errCnt = 0;
  int errors = 0, checks = 0;
  logic [7:0] txq[$];
  logic [7:0] expQ[$];
  int monBit = -1, monPh = 0;
  logic [7:0] monSh;

  uart_arith_host #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .OPERAND_WIDTH(W), .RX_TIMEOUT_CYCLES(400)) dut (
    .iClk(iClk), .iRst(iRst), .iRx(iRx), .oTx(oTx), .oStart(oStart), .oOpA(oOpA), .oOpB(oOpB),
    .oSub(oSub), .iRes(iRes), .iDone(iDone), .oBusy(oBusy), .oErr(oErr));

  always #5 iClk = ~iClk;
  assign iRes = addRes;

  always @(posedge iClk) begin
    if (oStart) begin
      startCnt <= startCnt + 1;
      seenA <= oOpA;
      seenB <= oOpB;
      seenSub <= oSub;
      addRes <= oSub ? {1'b0, oOpA} - {1'b0, oOpB} : {1'b0, oOpA} + {1'b0, oOpB};
      addCnt <= 3;
    end else if (addCnt != 0) addCnt <= addCnt - 1;
    iDone <= !iRst && !oStart && addCnt == 1;
    if (oErr) errCnt <= errCnt + 1;
  end

  always @(negedge iClk) begin
    if (iRst) monBit <= -1;
    else if (monBit < 0) begin
      if (!oTx) begin
        monBit <= 0;
        monPh <= CLKS + CLKS / 2;
      end
    end else if (monPh > 1) monPh <= monPh - 1;
    else if (monBit < 8) begin
      monSh <= {oTx, monSh[7:1]};
      monBit <= monBit + 1;
      monPh <= CLKS;
    end else begin
      if (oTx) txq.push_back(monSh);
      monBit <= -1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] d);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      iRx = f[i];
      repeat (CLKS) @(negedge iClk);
    end
  endtask

  task automatic sendFrame(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    sendByte(op);
    if (op <= 8'd1) begin
      sendByte(a[15:8]);
      sendByte(a[7:0]);
      sendByte(b[15:8]);
      sendByte(b[7:0]);
    end
  endtask

  task automatic waitBytes(input int n);
    for (int c = 0; c < 3000 && txq.size() < n; c++) @(negedge iClk);
  endtask

  // Reference: integer arithmetic, carry/borrow is any result outside 0..65535.
  task automatic buildExp(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    int s;
    expQ.delete();
    if (op > 8'd1) expQ.push_back(8'hEE);
    else begin
      s = op[0] ? int'(a) - int'(b) : int'(a) + int'(b);
      expQ.push_back(8'h00);
      expQ.push_back((s < 0 || s > 65535) ? 8'h01 : 8'h00);
      s = s & 16'hFFFF;
      expQ.push_back(8'(s / 256));
      expQ.push_back(8'(s % 256));
    end
  endtask

  task automatic runFrame(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    int s0, e0;
    buildExp(op, a, b);
    s0 = startCnt;
    e0 = errCnt;
    txq.delete();
    sendFrame(op, a, b);
    waitBytes(expQ.size());
    repeat (30) @(negedge iClk);
    check("nbytes", txq.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < txq.size(); i++) check($sformatf("byte%0d", i), txq[i], expQ[i]);
    check("starts", startCnt - s0, {31'd0, op <= 8'd1});
    check("errs", errCnt - e0, {31'd0, op > 8'd1});
    check("idle", oBusy, 0);
    if (op <= 8'd1) begin
      check("opA", seenA, a);
      check("opB", seenB, b);
      check("sub", seenSub, op[0]);
    end
  endtask

  initial begin
    repeat (5) @(negedge iClk);
    check("rst_tx", oTx, 1);
    check("rst_start", oStart, 0);
    check("rst_opA", oOpA, 0);
    check("rst_opB", oOpB, 0);
    check("rst_sub", oSub, 0);
    check("rst_busy", oBusy, 0);
    check("rst_err", oErr, 0);
    iRst = 1'b0;
    repeat (20) @(negedge iClk);
    runFrame(8'h00, 16'h1234, 16'h0001);
    runFrame(8'h00, 16'hFFFF, 16'h0001);
    runFrame(8'h01, 16'h0001, 16'h0002);
    runFrame(8'h7A, 16'h0000, 16'h0000);
    runFrame(8'h00, 16'h0000, 16'h0000);
    // Stall after the first operand byte.
    txq.delete();
    begin
      int e0;
      e0 = errCnt;
      sendByte(8'h00);
      sendByte(8'h12);
`ifdef UART_ARITH_TIMEOUT_EN
      waitBytes(1);
      repeat (30) @(negedge iClk);
      check("tmo_n", txq.size(), 1);
      if (txq.size() > 0) check("tmo_code", txq[0], 8'hEF);
      check("tmo_err", errCnt - e0, 1);
      check("tmo_idle", oBusy, 0);
`else
      repeat (1000) @(negedge iClk);
      check("tmo_n", txq.size(), 0);
      check("tmo_busy", oBusy, 1);
      check("tmo_err", errCnt - e0, 0);
      iRst = 1'b1;
      repeat (3) @(negedge iClk);
      iRst = 1'b0;
      repeat (10) @(negedge iClk);
`endif
    end
    // Reset during the third response byte.
    txq.delete();
    sendFrame(8'h00, 16'h1234, 16'h4321);
    waitBytes(2);
    for (int c = 0; c < 200 && oTx; c++) @(negedge iClk);
    check("mid_tx_low", oTx, 0);
    repeat (30) @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    check("abort_tx", oTx, 1);
    check("abort_busy", oBusy, 0);
    repeat (3) @(negedge iClk);
    iRst = 1'b0;
    repeat (300) @(negedge iClk);
    check("abort_n", txq.size(), 2);
    check("abort_tx_idle", oTx, 1);
    runFrame(8'h00, 16'hABCD, 16'h1111);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] op;
      op = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1));
      runFrame(op, 16'($urandom), 16'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
